// File: rtl/voucher_barcode_encoder.sv
// Voucher barcode transmitter: frames a 16-bit ID as timed Manchester-coded bar/space modules.
// Define VOUCHER_CHECKSUM_EN to insert the 4-bit XOR checksum segment between data and stop.
module voucher_barcode_encoder #(
  parameter int unsigned BIT_CYCLES    = 4,
  parameter int unsigned QUIET_MODULES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        print_start,
  input  logic [15:0] voucher_id,
  output logic        bar_out,
  output logic        bar_valid,
  output logic        busy,
  output logic        print_done
);

  localparam int unsigned CW     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned MaxSeg = (QUIET_MODULES > 32) ? QUIET_MODULES : 32;
  localparam int unsigned MW     = $clog2(MaxSeg);

  localparam logic [CW-1:0] CycLast   = CW'(BIT_CYCLES - 1);
  localparam logic [MW-1:0] QuietLast = MW'(QUIET_MODULES - 1);
  localparam logic [MW-1:0] GuardLast = MW'(3);
  localparam logic [MW-1:0] DataLast  = MW'(31);
`ifdef VOUCHER_CHECKSUM_EN
  localparam logic [MW-1:0] CheckLast = MW'(7);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StQuietLead,
    StStart,
    StData,
`ifdef VOUCHER_CHECKSUM_EN
    StCheck,
`endif
    StStop,
    StQuietTail
  } state_e;

  state_e          state_q, state_d, seg_next;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [MW-1:0]   mod_q, mod_d, seg_last;
  logic [15:0]     id_q, id_d;
  logic            done_q, done_d;

`ifdef VOUCHER_CHECKSUM_EN
  logic [3:0] chk;
  assign chk = id_q[15:12] ^ id_q[11:8] ^ id_q[7:4] ^ id_q[3:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      mod_q   <= '0;
      id_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      mod_q   <= mod_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    mod_d    = mod_q;
    id_d     = id_q;
    done_d   = 1'b0;
    bar_out  = 1'b0;
    seg_last = '0;
    seg_next = StIdle;

    // Manchester: even module carries the bit, odd module its complement.
    unique case (state_q)
      StIdle: ;
      StQuietLead: begin
        seg_last = QuietLast;
        seg_next = StStart;
      end
      StStart: begin
        seg_last = GuardLast;
        seg_next = StData;
        bar_out  = ~mod_q[0];
      end
      StData: begin
        seg_last = DataLast;
        bar_out  = id_q[4'd15 - mod_q[4:1]] ^ mod_q[0];
`ifdef VOUCHER_CHECKSUM_EN
        seg_next = StCheck;
`else
        seg_next = StStop;
`endif
      end
`ifdef VOUCHER_CHECKSUM_EN
      StCheck: begin
        seg_last = CheckLast;
        seg_next = StStop;
        bar_out  = chk[2'd3 - mod_q[2:1]] ^ mod_q[0];
      end
`endif
      StStop: begin
        seg_last = GuardLast;
        seg_next = StQuietTail;
        bar_out  = (mod_q[1:0] != 2'd2);
      end
      StQuietTail: begin
        seg_last = QuietLast;
        seg_next = StIdle;
      end
      default: ;
    endcase

    if (state_q == StIdle) begin
      if (print_start) begin
        state_d = StQuietLead;
        id_d    = voucher_id;
        cyc_d   = '0;
        mod_d   = '0;
      end
    end else if (cyc_q == CycLast) begin
      cyc_d = '0;
      if (mod_q == seg_last) begin
        mod_d   = '0;
        state_d = seg_next;
        done_d  = (state_q == StQuietTail);
      end else begin
        mod_d = mod_q + MW'(1);
      end
    end else begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  assign bar_valid  = (state_q != StIdle);
  assign busy       = (state_q != StIdle);
  assign print_done = done_q;

endmodule

// File: tb/tb_voucher_barcode_encoder.sv
// Directed bench for voucher_barcode_encoder: a default instance plus a BIT_CYCLES=1 instance.
module tb_voucher_barcode_encoder;

  localparam int Q = 8;
`ifdef VOUCHER_CHECKSUM_EN
  localparam bit ChkEn    = 1'b1;
  localparam int DataMods = 48;
`else
  localparam bit ChkEn    = 1'b0;
  localparam int DataMods = 40;
`endif
  localparam int M  = 2 * Q + DataMods;
  localparam int L0 = M * 4;
  localparam int L1 = M;
  localparam int ChkBase  = (Q + 4 + 32) * 4 + 1;
  localparam int StopBase = (Q + 4 + 32 + (ChkEn ? 8 : 0)) * 4 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ps0, ps1;
  logic [15:0] id0, id1;
  logic        bo0, bv0, bz0, pd0;
  logic        bo1, bv1, bz1, pd1;

  int checks   = 0;
  int failures = 0;
  logic rec [0:L0+1];

  voucher_barcode_encoder #(.BIT_CYCLES(4), .QUIET_MODULES(Q)) dut0 (
    .clk(clk), .reset_n(reset_n), .print_start(ps0), .voucher_id(id0),
    .bar_out(bo0), .bar_valid(bv0), .busy(bz0), .print_done(pd0)
  );

  voucher_barcode_encoder #(.BIT_CYCLES(1), .QUIET_MODULES(Q)) dut1 (
    .clk(clk), .reset_n(reset_n), .print_start(ps1), .voucher_id(id1),
    .bar_out(bo1), .bar_valid(bv1), .busy(bz1), .print_done(pd1)
  );

  // Expected module value for module index m of a frame carrying id.
  function automatic logic exp_mod(input logic [15:0] id, input int m);
    int r;
    logic [3:0] c;
    logic b;
    r = m;
    if (r < Q) return 1'b0;
    r -= Q;
    if (r < 4) return (r == 0 || r == 2) ? 1'b1 : 1'b0;
    r -= 4;
    if (r < 32) begin
      b = id[15 - r / 2];
      return (r % 2 == 0) ? b : ~b;
    end
    r -= 32;
    if (ChkEn) begin
      if (r < 8) begin
        c = id[15:12] ^ id[11:8] ^ id[7:4] ^ id[3:0];
        b = c[3 - r / 2];
        return (r % 2 == 0) ? b : ~b;
      end
      r -= 8;
    end
    if (r < 4) return (r != 2) ? 1'b1 : 1'b0;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [15:0] id, input int inject);
    int extra;
    ps0 = 1'b1;
    id0 = id;
    tick();
    ps0 = 1'b0;
    for (int c = 1; c <= L0; c++) begin
      rec[c] = bo0;
      checks++;
      if (bv0 !== 1'b1 || bz0 !== 1'b1 || pd0 !== 1'b0 || bo0 !== exp_mod(id, (c - 1) / 4)) begin
        failures++;
        $display("FAIL frame_cycle c=%0d got bar=%b valid=%b busy=%b done=%b want bar=%b 1 1 0",
                 c, bo0, bv0, bz0, pd0, exp_mod(id, (c - 1) / 4));
      end
      if (c == inject) begin
        ps0 = 1'b1;
        id0 = 16'h1234;
      end else begin
        ps0 = 1'b0;
      end
      tick();
    end
    checks++;
    if (bv0 !== 1'b0 || bz0 !== 1'b0 || bo0 !== 1'b0 || pd0 !== 1'b1) begin
      failures++;
      $display("FAIL frame_end got valid=%b busy=%b bar=%b done=%b want 0 0 0 1", bv0, bz0, bo0, pd0);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pd0 !== 1'b0 || bv0 !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL post_frame_idle got %0d bad cycles want 0", extra);
    end
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0;
    ps0 = 1'b0; ps1 = 1'b0; id0 = '0; id1 = '0;
    tick();
    tick();
    checks++;
    if ({bo0, bv0, bz0, pd0, bo1, bv1, bz1, pd1} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got %b want 00000000", {bo0, bv0, bz0, pd0, bo1, bv1, bz1, pd1});
    end
    reset_n = 1'b1;
    ps0 = 1'b1;
    id0 = 16'hABCD;
    tick();
    ps0 = 1'b0;
    repeat (40) tick();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bo0, bv0, bz0, pd0} !== 4'h0) begin
      failures++;
      $display("FAIL midframe_reset got %b want 0000", {bo0, bv0, bz0, pd0});
    end
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if ({bo0, bv0, bz0, pd0} !== 4'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_abort_idle got %0d bad cycles want 0", bad);
    end
    ps0 = 1'b1;
    tick();
    ps0 = 1'b0;
    checks++;
    if (bv0 !== 1'b1 || bz0 !== 1'b1 || bo0 !== 1'b0) begin
      failures++;
      $display("FAIL accept_after_reset got valid=%b busy=%b bar=%b want 1 1 0", bv0, bz0, bo0);
    end
    repeat (L0) tick();
    checks++;
    if (pd0 !== 1'b1 || bv0 !== 1'b0) begin
      failures++;
      $display("FAIL done_after_reset got done=%b valid=%b want 1 0", pd0, bv0);
    end
    tick();
  endtask

  task automatic test_abcd();
    int bad;
    logic [7:0] chk_mods;
    run_frame(16'hABCD, 0);
    bad = 0;
    for (int c = 1; c <= 32; c++) if (rec[c] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abcd_lead_quiet got %0d ones want 0", bad);
    end
    bad = 0;
    for (int k = 0; k < 16; k++) if (rec[33 + k] !== (((k / 4) % 2 == 0) ? 1'b1 : 1'b0)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abcd_start_guard got %0d wrong cycles want 0", bad);
    end
    checks++;
    if (rec[49] !== 1'b1 || rec[53] !== 1'b0) begin
      failures++;
      $display("FAIL abcd_first_data got %b%b want 10", rec[49], rec[53]);
    end
    if (ChkEn) begin
      chk_mods = 8'b01010101;
      bad = 0;
      for (int k = 0; k < 32; k++) if (rec[ChkBase + k] !== chk_mods[7 - k / 4]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL abcd_checksum got %0d wrong cycles want 0", bad);
      end
    end
  endtask

  task automatic test_1234();
    int bad;
    logic [7:0] chk_mods;
    logic [3:0] stop_mods;
    run_frame(16'h1234, 0);
    if (ChkEn) begin
      chk_mods = 8'b01100101;
      bad = 0;
      for (int k = 0; k < 32; k++) if (rec[ChkBase + k] !== chk_mods[7 - k / 4]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL c1234_checksum got %0d wrong cycles want 0", bad);
      end
    end
    stop_mods = 4'b1101;
    bad = 0;
    for (int k = 0; k < 16; k++) if (rec[StopBase + k] !== stop_mods[3 - k / 4]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL c1234_stop_guard got %0d wrong cycles want 0", bad);
    end
    bad = 0;
    for (int k = 16; k < 48; k++) if (rec[StopBase + k] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL c1234_tail_quiet got %0d ones want 0", bad);
    end
  endtask

  task automatic test_ignore_start();
    run_frame(16'hABCD, 100);
  endtask

  task automatic test_back_to_back();
    int bad;
    ps0 = 1'b1;
    id0 = 16'hABCD;
    tick();
    bad = 0;
    for (int c = 1; c <= L0; c++) begin
      if (bv0 !== 1'b1 || pd0 !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_first_frame got %0d bad cycles want 0", bad);
    end
    checks++;
    if (bv0 !== 1'b0 || pd0 !== 1'b1 || bo0 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap1 got valid=%b done=%b bar=%b want 0 1 0", bv0, pd0, bo0);
    end
    tick();
    bad = 0;
    for (int c = 1; c <= L0; c++) begin
      if (bv0 !== 1'b1 || pd0 !== 1'b0 || bo0 !== exp_mod(16'hABCD, (c - 1) / 4)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_second_frame got %0d bad cycles want 0", bad);
    end
    checks++;
    if (bv0 !== 1'b0 || pd0 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap2 got valid=%b done=%b want 0 1", bv0, pd0);
    end
    ps0 = 1'b0;
    tick();
    checks++;
    if (bv0 !== 1'b0 || pd0 !== 1'b0 || bz0 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_release got valid=%b done=%b busy=%b want 0 0 0", bv0, pd0, bz0);
    end
  endtask

  task automatic test_bit_cycles_one();
    int bad;
    int dbad;
    ps1 = 1'b1;
    id1 = 16'hFFFF;
    tick();
    ps1 = 1'b0;
    bad = 0;
    dbad = 0;
    for (int c = 1; c <= L1; c++) begin
      if (bv1 !== 1'b1 || bz1 !== 1'b1 || pd1 !== 1'b0 || bo1 !== exp_mod(16'hFFFF, c - 1)) bad++;
      if (c >= 13 && c <= 44 && bo1 !== (((c - 13) % 2 == 0) ? 1'b1 : 1'b0)) dbad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bc1_frame got %0d bad cycles want 0", bad);
    end
    checks++;
    if (dbad != 0) begin
      failures++;
      $display("FAIL bc1_data_pairs got %0d bad cycles want 0", dbad);
    end
    checks++;
    if (pd1 !== 1'b1 || bv1 !== 1'b0 || bo1 !== 1'b0) begin
      failures++;
      $display("FAIL bc1_end got done=%b valid=%b bar=%b want 1 0 0", pd1, bv1, bo1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_abcd();
    test_1234();
    test_ignore_start();
    test_back_to_back();
    test_bit_cycles_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
